decode_seq: RTL
===============

# decode_seq

Decode-stage sequencer for the RV32I core. Sits between instruction fetch and the `decode` block: it holds the instruction register, drives decode's `FLUSH`/`XRES` controls, sequences the post-reset and post-branch flush windows, and inserts load-use interlock bubbles. One instruction per cycle in steady state, with a valid/ready handshake toward fetch.

## Interface
- `RST_CYCLES`, default 2: cycles `OXRES` stays high after reset release; legal range 1..15.
- `FLUSH_CYCLES`, default 2: cycles `OFLUSH` stays high after a taken redirect; legal range 1..15.
- `CLK` in 1: core clock, rising edge.
- `RESN` in 1: reset, asynchronous assert, active-low.
- `IVALID` in 1: fetch presents `IDATA`.
- `IDATA` in 32: fetched instruction word.
- `IREADY` out 1: sequencer accepts `IDATA` this cycle.
- `HALT` in 1: global core hold (bus wait).
- `JMP_TAKEN` in 1: execute stage redirects the PC (taken branch, JAL, JALR).
- `LCC_EX` in 1: instruction in execute is a load.
- `DPTR_EX` in 5: destination register of the instruction in execute.
- `OVALID` out 1: `ODATA` is a live instruction for decode/execute.
- `ODATA` out 32: instruction to decode (`IDATA` of decode); 0 when `OVALID`=0.
- `OFLUSH` out 1: drives decode `FLUSH`.
- `OXRES` out 1: drives decode `XRES`.

## Operation
- State is one of RST, RUN, FLSH. Registers: state, `IR` (32), `irv` (1), and a 4-bit counter `cnt`.
- Async reset (`RESN`=0, at any time, including mid-flush or mid-stall): state=RST, `cnt`=`RST_CYCLES`-1, `IR`=0, `irv`=0.
- Output reset values: `IREADY`=0, `OVALID`=0, `ODATA`=0, `OFLUSH`=1, `OXRES`=1.
- RST:
  - `OXRES`=1, `OFLUSH`=1, `IREADY`=0.
  - `cnt` decrements each non-HALT cycle. At `cnt`=0 the next state is RUN.
  - `JMP_TAKEN` is ignored.
- RUN:
  - `OXRES`=0, `OFLUSH`=0.
  - `IREADY` = !`HALT` && !`ilock` && !`JMP_TAKEN`.
  - On `IVALID`&&`IREADY`: `IR`<=`IDATA`, `irv`<=1.
  - On `IREADY`&&!`IVALID`: `irv`<=0 (bubble).
- ilock (load-use interlock), combinational: `irv` && `LCC_EX` && `DPTR_EX`!=0 && (`DPTR_EX`==`IR[19:15]` || `DPTR_EX`==`IR[24:20]`).
  - While ilock is high, `IR` and `irv` hold, and `OVALID` is forced 0 so a bubble enters execute.
- FLSH:
  - `OFLUSH`=1, `OXRES`=0, `IREADY`=!`HALT`.
  - Accepted words are discarded and `irv` stays 0.
  - `cnt` decrements each non-HALT cycle. At `cnt`=0 the next state is RUN.
- Outputs: `OVALID` = `irv` && !ilock && state==RUN. `ODATA` = `OVALID` ? `IR` : 0.
- Priority within a non-HALT cycle: reset > `JMP_TAKEN` > ilock > normal accept.
  - `JMP_TAKEN` in RUN: `irv`<=0, state<=FLSH, `cnt`<=`FLUSH_CYCLES`-1. Any concurrent `IDATA` is not accepted.
  - `JMP_TAKEN` in FLSH: `cnt` reloads to `FLUSH_CYCLES`-1 (window restarts).
- `HALT`=1 freezes all state, including `cnt`.
  - `IREADY`=0.
  - `OVALID`/`ODATA` keep their combinational values.
  - `JMP_TAKEN` is ignored, because execute is also halted.

## Timing
- Fetch-to-decode latency is 1 cycle: a word accepted at edge N appears on `ODATA` after edge N.
- Throughput is 1 instruction/cycle with no ilock, `HALT` or flush.
- First `IREADY`=1 occurs `RST_CYCLES` cycles after the first edge with `RESN`=1.
- Each ilock costs exactly one bubble per load, assuming execute advances `LCC_EX` in the next cycle.
- `OFLUSH` rises one edge after `JMP_TAKEN` and stays high for exactly `FLUSH_CYCLES` non-HALT cycles. The first post-flush word can be accepted in the first RUN cycle.
- Fetch may drop `IVALID` at any time. `IDATA` only needs to be stable while `IVALID`&&`IREADY`.

## Configuration
- `DECODE_SEQ_INTERLOCK_EN` defined: load-use interlock as described.
- Undefined:
  - ilock is constant 0.
  - `LCC_EX` and `DPTR_EX` are unused.
  - Software or the core's own forwarding must cover load-use hazards.

## Structure
- Package `decode_seq_pkg`:
  - state enum (RST, RUN, FLSH).
  - RV32I field positions (rs1 19:15, rs2 24:20).
  - opcode constants for LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, CUS, CCC, shared with decode.
- Sub-module `decode_seq_ilock` (combinational hazard compare). All else is flat.

## Test plan
- Reset/startup: release `RESN` with `RST_CYCLES`=2 -> `OXRES`=1 for 2 cycles, then `IREADY`=1; `OVALID`=0 throughout.
- Streaming: drive 4 back-to-back words 0x00500093, 0x00108113, ... -> each appears on `ODATA` one cycle after accept, with `OVALID`=1 every cycle.
- Load-use: `IR`=0x002081B3 (rs1=1, rs2=2), `LCC_EX`=1, `DPTR_EX`=2 -> exactly one cycle with `OVALID`=0 and `IREADY`=0, then resume. Same stimulus with `DPTR_EX`=0 -> no bubble.
- Redirect: `JMP_TAKEN` with `FLUSH_CYCLES`=2 while `IVALID`=1 -> `OFLUSH`=1 for 2 cycles, 2 fetched words discarded, third word issued. A second `JMP_TAKEN` mid-flush -> window extends to 2 cycles from that point.
- `HALT`: assert for 3 cycles mid-stream and mid-flush -> `IR`, `cnt`, `ODATA` unchanged, `IREADY`=0, `JMP_TAKEN` ignored.
- Async reset mid-flush: drop `RESN` between edges -> outputs go to reset values immediately, then the startup sequence repeats.

Source files
------------

// File: rtl/decode_seq_pkg.sv
// Shared types and RV32I encoding constants for the decode-stage sequencer
// and the decode block.
package decode_seq_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_FLSH = 2'd2
    } seq_state_t;

    localparam int REG_W   = 5;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    // Major opcodes, bits [6:0] of the instruction word.
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BCC   = 7'b1100011;
    localparam logic [6:0] OPC_LCC   = 7'b0000011;
    localparam logic [6:0] OPC_SCC   = 7'b0100011;
    localparam logic [6:0] OPC_MCC   = 7'b0010011;
    localparam logic [6:0] OPC_RCC   = 7'b0110011;
    localparam logic [6:0] OPC_CUS   = 7'b0001011;
    localparam logic [6:0] OPC_CCC   = 7'b1110011;

endpackage

// File: rtl/decode_seq_ilock.sv
// Load-use hazard compare: flags when the load in execute writes a source
// register of the instruction held for decode.
module decode_seq_ilock
    import decode_seq_pkg::*;
(
    input  logic             irv,
    input  logic             lcc_ex,
    input  logic [REG_W-1:0] dptr_ex,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             ilock
);

    // x0 is never a real destination, so a load into it cannot create a hazard.
    always_comb begin
        ilock = irv && lcc_ex && (dptr_ex != '0) &&
                ((dptr_ex == rs1) || (dptr_ex == rs2));
    end

endmodule

// File: rtl/decode_seq.sv
// Decode-stage sequencer: instruction register, reset/flush windows and
// load-use bubbles. Interlock is built only when DECODE_SEQ_INTERLOCK_EN is defined.
module decode_seq
    import decode_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESN,
    input  logic             IVALID,
    input  logic [31:0]      IDATA,
    output logic             IREADY,
    input  logic             HALT,
    input  logic             JMP_TAKEN,
    input  logic             LCC_EX,
    input  logic [REG_W-1:0] DPTR_EX,
    output logic             OVALID,
    output logic [31:0]      ODATA,
    output logic             OFLUSH,
    output logic             OXRES
);

    localparam logic [3:0] RST_LOAD   = 4'(RST_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    seq_state_t  state, state_nxt;
    logic [31:0] ir, ir_nxt;
    logic        irv, irv_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        ilock;

`ifdef DECODE_SEQ_INTERLOCK_EN
    decode_seq_ilock u_ilock (
        .irv     (irv),
        .lcc_ex  (LCC_EX),
        .dptr_ex (DPTR_EX),
        .rs1     (ir[RS1_MSB:RS1_LSB]),
        .rs2     (ir[RS2_MSB:RS2_LSB]),
        .ilock   (ilock)
    );
`else
    logic unused_ilock_inputs;
    assign unused_ilock_inputs = ^{LCC_EX, DPTR_EX};
    assign ilock = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state <= ST_RST;
            cnt   <= RST_LOAD;
            ir    <= '0;
            irv   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ir    <= ir_nxt;
            irv   <= irv_nxt;
        end
    end

    // HALT gates every state change; a redirect outranks the interlock.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ir_nxt    = ir;
        irv_nxt   = irv;
        IREADY    = 1'b0;
        OFLUSH    = 1'b0;
        OXRES     = 1'b0;
        case (state)
            ST_RST: begin
                OXRES  = 1'b1;
                OFLUSH = 1'b1;
                if (!HALT) begin
                    if (cnt == 4'd0) state_nxt = ST_RUN;
                    else             cnt_nxt   = cnt - 4'd1;
                end
            end
            ST_FLSH: begin
                OFLUSH  = 1'b1;
                IREADY  = !HALT;
                irv_nxt = 1'b0;
                if (!HALT) begin
                    if (JMP_TAKEN)         cnt_nxt   = FLUSH_LOAD;
                    else if (cnt == 4'd0)  state_nxt = ST_RUN;
                    else                   cnt_nxt   = cnt - 4'd1;
                end
            end
            ST_RUN: begin
                IREADY = !HALT && !ilock && !JMP_TAKEN;
                if (!HALT) begin
                    if (JMP_TAKEN) begin
                        irv_nxt   = 1'b0;
                        state_nxt = ST_FLSH;
                        cnt_nxt   = FLUSH_LOAD;
                    end else if (!ilock) begin
                        if (IVALID) begin
                            ir_nxt  = IDATA;
                            irv_nxt = 1'b1;
                        end else begin
                            irv_nxt = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_RST;
                cnt_nxt   = RST_LOAD;
                irv_nxt   = 1'b0;
            end
        endcase
    end

    assign OVALID = irv && !ilock && (state == ST_RUN);
    assign ODATA  = OVALID ? ir : 32'd0;

endmodule
